// File: rtl/uart_hex_sample_rx.sv
// uart_hex_sample_rx: parses LF-terminated six-digit ASCII-hex lines into a sample FIFO popped by DAC requests.
// Define UART_HEX_RX_SIGNED_EN to convert offset-binary text to two's complement (bit 23 inverted on push).
module uart_hex_sample_rx #(
  parameter int DEPTH = 1024,
  parameter int SAMPLE_BITS = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic [7:0]               rdata,
  input  logic                     flush,
  input  logic                     dac_req,
  output logic [SAMPLE_BITS-1:0]   sample_out,
  output logic                     sample_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow,
  output logic [7:0]               err_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DIGITS, DISCARD} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] acc_q, acc_d, out_q, out_d, push_data;
  logic [SAMPLE_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  logic [7:0] err_q, err_d;
  logic rready_q, rready_d, valid_q, valid_d, uf_q, uf_d;
  logic hs, is_lf, is_cr, is_dig, is_hex, full, push, pop, err_inc, acceptable;
  logic [3:0] nib;
  assign hs = rvalid && rready_q;
  assign is_lf = rdata == 8'h0A;
  assign is_cr = rdata == 8'h0D;
  assign is_dig = rdata >= 8'h30 && rdata <= 8'h39;
  assign is_hex = is_dig || (rdata >= 8'h41 && rdata <= 8'h46) || (rdata >= 8'h61 && rdata <= 8'h66);
  assign nib = is_dig ? rdata[3:0] : rdata[3:0] + 4'd9;
  assign full = level_q == (AW+1)'(DEPTH);
  assign pop = dac_req && level_q != '0 && !flush;
`ifdef UART_HEX_RX_SIGNED_EN
  assign push_data = {~acc_q[SAMPLE_BITS-1], acc_q[SAMPLE_BITS-2:0]};
`else
  assign push_data = acc_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    push = 1'b0;
    err_inc = 1'b0;
    if (hs && !is_cr) begin
      if (state_q == DISCARD) begin
        if (is_lf) state_d = IDLE;
      end else if (is_hex) begin
        if (cnt_q == 3'd6) begin
          state_d = DISCARD;
          err_inc = 1'b1;
        end else begin
          state_d = DIGITS;
          cnt_d = cnt_q + 3'd1;
          acc_d = {acc_q[SAMPLE_BITS-5:0], nib};
        end
      end else if (is_lf) begin
        state_d = IDLE;
        push = cnt_q == 3'd6;
        err_inc = cnt_q != 3'd0 && cnt_q != 3'd6;
      end else begin
        state_d = DISCARD;
        err_inc = 1'b1;
      end
    end
    if (flush) state_d = IDLE;
    if (state_d != DIGITS) cnt_d = '0;
    push = push && !flush;
    err_inc = err_inc && !flush;
  end
  // A complete line's LF is held off while the FIFO is full so no sample is ever dropped.
  always_comb begin
    acceptable = !(is_lf && state_q == DIGITS && cnt_q == 3'd6 && full);
    rready_d = !flush && (hs ? 1'b0 : (rready_q || (rvalid && acceptable)));
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    level_d = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    out_d = pop ? mem_q[rptr_q] : out_q;
    valid_d = pop;
    uf_d = !flush && (uf_q || (dac_req && level_q == '0));
    err_d = flush ? '0 : err_q + 8'(err_inc && err_q != 8'hFF);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      out_q <= '0;
      err_q <= '0;
      rready_q <= 1'b0;
      valid_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      out_q <= out_d;
      err_q <= err_d;
      rready_q <= rready_d;
      valid_q <= valid_d;
      uf_q <= uf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end
  assign rready = rready_q;
  assign sample_out = out_q;
  assign sample_valid = valid_q;
  assign fifo_level = level_q;
  assign underflow = uf_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_uart_hex_sample_rx.sv
// tb_uart_hex_sample_rx: directed bench for the hex line parser, FIFO full/wrap, underflow, flush and reset.
module tb_uart_hex_sample_rx;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, rvalid = 1'b0, flush = 1'b0, dac_req = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic rready, sample_valid, underflow, seen;
  logic [23:0] sample_out;
  logic [3:0] fifo_level;
  logic [7:0] err_count;
  logic [23:0] v [8];
  int passed = 0, total = 0;
  uart_hex_sample_rx #(.DEPTH(DEPTH), .SAMPLE_BITS(24)) dut (
    .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .flush(flush), .dac_req(dac_req), .sample_out(sample_out), .sample_valid(sample_valid),
    .fifo_level(fifo_level), .underflow(underflow), .err_count(err_count)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] xf(input logic [23:0] t);
`ifdef UART_HEX_RX_SIGNED_EN
    return t ^ 24'h800000;
`else
    return t;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic req = 1'b0);
    logic got;
    got = 1'b0;
    rvalid = 1'b1;
    rdata = b;
    for (int n = 0; n < 40 && !got; n++) begin
      got = rready;
      if (got) dac_req = req;
      @(negedge clk);
    end
    rvalid = 1'b0;
    dac_req = 1'b0;
    chk("handshake", {31'b0, got}, 1);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic pop();
    dac_req = 1'b1;
    @(negedge clk);
    dac_req = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_out"}, sample_out, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_lvl"}, fifo_level, 0);
    chk({tag, "_uf"}, underflow, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [23:0] t;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    send_str("800000\015\n");
    chk("s1_lvl1", fifo_level, 1);
    pop();
    chk("s1_out", sample_out, xf(24'h800000));
    chk("s1_valid", sample_valid, 1);
    chk("s1_lvl0", fifo_level, 0);
    @(negedge clk);
    chk("s1_pulse", sample_valid, 0);
    send_str("00aBcD\n1\n12G456\n\n");
    send_str("FFFFFF\n");
    chk("mix_err", err_count, 2);
    chk("mix_lvl", fifo_level, 2);
    pop();
    chk("mix_s0", sample_out, xf(24'h00ABCD));
    pop();
    chk("mix_s1", sample_out, xf(24'hFFFFFF));
    chk("mix_lvl0", fifo_level, 0);
    send_str("123456");
    send_byte(8'h0A, 1'b1);
    chk("uf_flag", underflow, 1);
    chk("uf_valid", sample_valid, 0);
    chk("uf_out", sample_out, xf(24'hFFFFFF));
    chk("uf_lvl", fifo_level, 1);
    pop();
    chk("uf_pop", sample_out, xf(24'h123456));
    send_str("Z\n");
    chk("fl_err3", err_count, 3);
    for (int i = 0; i < 5; i++) begin
      t = 24'h000010 + 24'(i);
      send_str($sformatf("%h\n", t));
    end
    chk("fl_lvl5", fifo_level, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_lvl", fifo_level, 0);
    chk("fl_err", err_count, 0);
    chk("fl_uf", underflow, 0);
    chk("fl_rready", rready, 0);
    chk("fl_out", sample_out, xf(24'h123456));
    pop();
    chk("empty_uf", underflow, 1);
    chk("empty_valid", sample_valid, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl2_uf", underflow, 0);
    for (int i = 0; i < 8; i++) begin
      v[i] = 24'hA1B2C3 + 24'(i) * 24'h111111;
      send_str($sformatf("%h\n", v[i]));
    end
    chk("full_lvl", fifo_level, DEPTH);
    send_str("abcdef");
    rvalid = 1'b1;
    rdata = 8'h0A;
    seen = 1'b0;
    repeat (6) begin
      seen |= rready;
      @(negedge clk);
    end
    chk("full_stall", seen, 0);
    pop();
    chk("full_pop0", sample_out, xf(v[0]));
    send_byte(8'h0A);
    chk("full_relvl", fifo_level, DEPTH);
    for (int i = 1; i < 8; i++) begin
      pop();
      chk($sformatf("order%0d", i), sample_out, xf(v[i]));
    end
    pop();
    chk("order_wrap", sample_out, xf(24'hABCDEF));
    chk("order_lvl0", fifo_level, 0);
    send_str("12");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    @(negedge clk);
    send_str("345678\n");
    chk("rl_lvl", fifo_level, 1);
    chk("rl_err", err_count, 0);
    pop();
    chk("rl_out", sample_out, xf(24'h345678));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_hex_sample_rx.md
# uart_hex_sample_rx

Receive-side counterpart of the ADC capture path: parses the ASCII-hex sample stream (six uppercase/lowercase hex digits per 24-bit sample, LF-terminated, CR ignored) from the UART byte interface. Decoded samples are buffered in a FIFO and released one per request strobe to a sigma-delta DAC. The block sits between the `uart` receive port and the DAC's sample input, so captured waveforms can be replayed through the hardware.

## Interface
- `DEPTH`, 1024: FIFO depth in samples; power of two, ≥ 4.
- `SAMPLE_BITS`, 24: sample width; fixed at 24 (six digits).
- `clk` in 1: single clock.
- `rst` in 1: reset; asynchronous, active-high.
- `rvalid` in 1: UART received byte valid; held until handshake.
- `rready` out 1: byte accept; handshake when `rvalid & rready`.
- `rdata` in 8: received byte.
- `flush` in 1: synchronous clear of FIFO, parser, flags.
- `dac_req` in 1: one-cycle strobe; DAC wants next sample.
- `sample_out` out 24: current DAC sample.
- `sample_valid` out 1: one-cycle pulse, new sample on `sample_out`.
- `fifo_level` out $clog2(DEPTH)+1: samples stored.
- `underflow` out 1: sticky; `dac_req` seen with FIFO empty.
- `err_count` out 8: saturating count of malformed lines.

## Operation
- Byte handshake: `rready` is registered. Set the cycle after `rvalid=1`, `rready=0` and the byte is acceptable; cleared on the cycle after a handshake. Max one byte per 2 cycles.
- Acceptable: any byte, except LF while the parser holds 6 digits and the FIFO is full. In that case `rready` stays 0 until a pop frees space.
- Parser states:
  - IDLE (digit count 0)
  - DIGITS (count 1..6, shift register accumulates `{acc[19:0], nibble}`)
  - DISCARD
- Transitions:
  - Hex digit `0-9`/`A-F`/`a-f`: IDLE/DIGITS with count <6 → count+1. Seventh digit → DISCARD, `err_count`+1.
  - CR (0x0D): ignored in every state.
  - LF (0x0A) with count 6: push accumulator, → IDLE.
  - LF with count 1..5: `err_count`+1, → IDLE. LF with count 0 (blank line): → IDLE, no error.
  - Any other byte in IDLE/DIGITS: `err_count`+1, → DISCARD.
  - DISCARD: drop bytes until LF, then → IDLE (no further error count).
- `err_count` saturates at 255.
- FIFO: circular buffer, read/write pointers wrap at `DEPTH`. Push and pop in the same cycle are both performed and the level is unchanged.
- Pop: on `dac_req` with level >0, the head is registered to `sample_out` and `sample_valid` pulses. With level 0, `sample_out` holds its last value, `sample_valid` stays 0 and `underflow` sets. There is no same-cycle bypass: a push coincident with a `dac_req` on an empty FIFO still underflows.
- `flush`: level→0, pointers→0, parser→IDLE, `underflow`→0, `err_count`→0, `rready`→0. `sample_out` is held. `flush` has priority over a coincident push/pop.

## Timing
- Reset values: `rready`=0, `sample_out`=0, `sample_valid`=0, `fifo_level`=0, `underflow`=0, `err_count`=0, parser IDLE.
- Reset mid-line discards partial digits; reset mid-handshake drops the byte.
- Latency:
  - LF handshake cycle → push. `fifo_level` increments on the next edge.
  - `dac_req` at edge N → `sample_out`/`sample_valid` valid after edge N+1.
- A back-to-back `dac_req` every cycle is supported. Each request pops one sample.
- `underflow` sets on the edge after the empty-FIFO request.

## Configuration
- `UART_HEX_RX_SIGNED_EN`:
  - Defined: decoded text is treated as offset binary (as the ADC emits with unsigned output). Bit 23 is inverted on push, so `sample_out` is two's complement.
  - Undefined: the value is stored unmodified. Reset `sample_out` is 0 in both cases.

## Test plan
- Send "800000\r\n", then `dac_req`:
  - `fifo_level` 0→1→0.
  - `sample_out`=0x800000 (0x000000 with `UART_HEX_RX_SIGNED_EN`), one `sample_valid` pulse.
- Send "00aBcD\n1\n12G456\n\n" then "FFFFFF\n":
  - Exactly two samples, 0x00ABCD and 0xFFFFFF.
  - `err_count`=2.
- Fill `DEPTH` samples, send one more line:
  - `rready` stays 0 on its LF.
  - After one `dac_req`, the LF is accepted and the level returns to `DEPTH`. No sample is lost and FIFO order is preserved across wrap-around.
- `dac_req` with the FIFO empty:
  - `underflow`=1, `sample_valid`=0, `sample_out` unchanged.
  - A push in the same cycle still leaves `fifo_level`=1.
- Assert `rst` after "12" of a line, then send "345678\n":
  - Single sample 0x345678. All outputs at reset values during reset.
- `flush` with 5 samples queued and `err_count`=3:
  - Level 0, `err_count` 0, `underflow` 0 on the next edge.
